data_mem_responder: RTL

Responder side of the memory-stage data interface. Accepts one load or store per request from the processor's memory stage, performs RV32I byte/halfword/word access with sign or zero extension, and inserts a configurable number of wait states. While a request is in flight it asserts `stall` so the pipeline holds, then returns a one-cycle response carrying load data or an access error.

---
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Memory-stage <-> data memory responder bus.
// Handshake: the master raises req_valid with a stable request and holds it (with
// identical fields) until the cycle after resp_valid. stall is the responder's
// not-ready; resp_valid is a one-cycle completion pulse, access_err qualifies it.
interface data_mem_responder_if;
  logic        req_valid;
  logic        mem_wr;
  logic [2:0]  rd_wr_mem;
  logic [31:0] addr_mem;
  logic [31:0] wdata_mem;
  logic [31:0] rdata_mem;
  logic        resp_valid;
  logic        stall;
  logic        access_err;

  modport master (
    output req_valid, mem_wr, rd_wr_mem, addr_mem, wdata_mem,
    input  rdata_mem, resp_valid, stall, access_err
  );

  modport slave (
    input  req_valid, mem_wr, rd_wr_mem, addr_mem, wdata_mem,
    output rdata_mem, resp_valid, stall, access_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// RV32I data memory responder: byte/half/word loads and stores with a fixed
// number of wait states, stall while busy, and a one-cycle response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           dbg_state
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_q, resp_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // With zero wait states the access commits straight from IDLE, before the
  // request has been latched, so the commit path uses the live bus fields.
  logic          cur_wr;
  logic [2:0]    cur_f3;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_idx;
  logic          commit;
  logic          illegal;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic [31:0]   word;
  logic [31:0]   byte_sh;
  logic [15:0]   half;
  logic [31:0]   load_val;
  logic          wr_en;
  logic          unused_addr_bits;

  assign cur_wr    = (state_q == ST_IDLE) ? bus.mem_wr    : wr_q;
  assign cur_f3    = (state_q == ST_IDLE) ? bus.rd_wr_mem : f3_q;
  assign cur_addr  = (state_q == ST_IDLE) ? bus.addr_mem  : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ? bus.wdata_mem : wdata_q;
  assign cur_idx   = cur_addr[AW+1:2];
  assign unused_addr_bits = ^cur_addr[31:AW+2];

  assign commit = ((state_q == ST_IDLE) && bus.req_valid && (WAIT_STATES == 0)) ||
                  ((state_q == ST_WAIT) && (cnt_q == 4'd1));

  always_comb begin
    illegal = 1'b1;
    case (cur_f3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = cur_addr[0];
      3'b010:  illegal = (cur_addr[1:0] != 2'b00);
      3'b100:  illegal = cur_wr;
      3'b101:  illegal = cur_wr | cur_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    lane_en   = 4'b0000;
    lane_data = cur_wdata;
    case (cur_f3)
      3'b000: begin
        lane_en   = 4'b0001 << cur_addr[1:0];
        lane_data = {4{cur_wdata[7:0]}};
      end
      3'b001: begin
        lane_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{cur_wdata[15:0]}};
      end
      3'b010:  lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  assign word    = mem[cur_idx];
  assign byte_sh = word >> {cur_addr[1:0], 3'b000};
  assign half    = cur_addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    case (cur_f3)
      3'b000:  load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_val = {24'd0, byte_sh[7:0]};
      3'b001:  load_val = {{16{half[15]}}, half};
      3'b101:  load_val = {16'd0, half};
      default: load_val = word;
    endcase
  end

  // Gated by reset so a zero-wait store cannot slip in while reset is held.
  assign wr_en = commit && cur_wr && !illegal && reset;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[cur_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wr_d    = bus.mem_wr;
          f3_d    = bus.rd_wr_mem;
          addr_d  = bus.addr_mem;
          wdata_d = bus.wdata_mem;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      resp_d = 1'b1;
      err_d  = illegal;
      if (!cur_wr) rdata_d = illegal ? 32'd0 : load_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall      = ((state_q == ST_IDLE) && bus.req_valid) || (state_q == ST_WAIT);
  assign bus.rdata_mem  = rdata_q;
  assign bus.resp_valid = resp_q;
  assign bus.access_err = err_q;
  assign dbg_state      = state_q;
endmodule
